// File: rtl/regfile_write_arbiter.sv
// Write-port arbiter for the register file: buffers one result each from the ALU and the load unit,
// issues one registered write per cycle oldest-first, and exports a pending-write mask. Optional: WB_BYPASS_EN.
`timescale 1ns/1ps
module regfile_write_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                   clock,
    input  logic                   resetN,
    input  logic                   aluValid,
    output logic                   aluReady,
    input  logic [ADDR_W-1:0]      aluReg,
    input  logic [DATA_W-1:0]      aluData,
    input  logic                   memValid,
    output logic                   memReady,
    input  logic [ADDR_W-1:0]      memReg,
    input  logic [DATA_W-1:0]      memData,
    output logic                   regWrite,
    output logic [ADDR_W-1:0]      writeReg,
    output logic [DATA_W-1:0]      writeData,
    output logic [2**ADDR_W-1:0]   busyMask
);

    localparam int NREG = 2**ADDR_W;

    logic              alu_vld, mem_vld;
    logic [ADDR_W-1:0] alu_reg_q, mem_reg_q;
    logic [DATA_W-1:0] alu_data_q, mem_data_q;
    // Set when the memory buffer holds the older of two occupied entries.
    logic              mem_older;

    logic grant_alu, grant_mem;
    logic alu_xfer, mem_xfer;
    logic alu_load, mem_load;
    logic alu_keep, mem_keep;
    logic byp_alu, byp_mem;

    always_comb begin
        grant_mem = mem_vld && (!alu_vld || mem_older);
        grant_alu = alu_vld && !grant_mem;
        aluReady  = resetN && (!alu_vld || grant_alu);
        memReady  = resetN && (!mem_vld || grant_mem);
        alu_xfer  = aluValid && aluReady;
        mem_xfer  = memValid && memReady;
        alu_load  = alu_xfer && (aluReg != '0);
        mem_load  = mem_xfer && (memReg != '0);
        alu_keep  = alu_vld && !grant_alu;
        mem_keep  = mem_vld && !grant_mem;
`ifdef WB_BYPASS_EN
        // Straight-through only when nothing is queued and the other side is silent,
        // so acceptance order is preserved trivially.
        byp_alu   = alu_load && !mem_xfer && !alu_vld && !mem_vld;
        byp_mem   = mem_load && !alu_xfer && !alu_vld && !mem_vld;
`else
        byp_alu   = 1'b0;
        byp_mem   = 1'b0;
`endif
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            alu_vld    <= 1'b0;
            mem_vld    <= 1'b0;
            alu_reg_q  <= '0;
            mem_reg_q  <= '0;
            alu_data_q <= '0;
            mem_data_q <= '0;
            mem_older  <= 1'b0;
        end else begin
            alu_vld <= alu_keep || (alu_load && !byp_alu);
            mem_vld <= mem_keep || (mem_load && !byp_mem);
            if (alu_load) begin
                alu_reg_q  <= aluReg;
                alu_data_q <= aluData;
            end
            if (mem_load) begin
                mem_reg_q  <= memReg;
                mem_data_q <= memData;
            end
            // A surviving entry is older than anything loaded now; on a tie mem goes first.
            mem_older <= mem_keep || !alu_keep;
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            regWrite  <= 1'b0;
            writeReg  <= '0;
            writeData <= '0;
        end else if (grant_mem) begin
            regWrite  <= 1'b1;
            writeReg  <= mem_reg_q;
            writeData <= mem_data_q;
        end else if (grant_alu) begin
            regWrite  <= 1'b1;
            writeReg  <= alu_reg_q;
            writeData <= alu_data_q;
        end else if (byp_alu) begin
            regWrite  <= 1'b1;
            writeReg  <= aluReg;
            writeData <= aluData;
        end else if (byp_mem) begin
            regWrite  <= 1'b1;
            writeReg  <= memReg;
            writeData <= memData;
        end else begin
            regWrite  <= 1'b0;
        end
    end

    always_comb begin
        busyMask = '0;
        for (int i = 0; i < NREG; i++) begin
            if ((alu_vld && alu_reg_q == ADDR_W'(i)) ||
                (mem_vld && mem_reg_q == ADDR_W'(i)) ||
                (regWrite && writeReg == ADDR_W'(i)))
                busyMask[i] = 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with a register-file model and a commit log.
`timescale 1ns/1ps
module tb_regfile_write_arbiter;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              clock = 1'b0;
    logic              resetN = 1'b0;
    logic              aluValid, memValid;
    logic              aluReady, memReady;
    logic [ADDR_W-1:0] aluReg, memReg;
    logic [DATA_W-1:0] aluData, memData;
    logic              regWrite;
    logic [ADDR_W-1:0] writeReg;
    logic [DATA_W-1:0] writeData;
    logic [31:0]       busyMask;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0]        rf [32];
    logic [ADDR_W+DATA_W-1:0] wlog [$];

    regfile_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clock(clock), .resetN(resetN),
        .aluValid(aluValid), .aluReady(aluReady), .aluReg(aluReg), .aluData(aluData),
        .memValid(memValid), .memReady(memReady), .memReg(memReg), .memData(memData),
        .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData), .busyMask(busyMask)
    );

    always #5 clock = ~clock;

    // Register file commits whatever the arbiter presented during the previous cycle.
    always @(posedge clock) begin
        if (resetN && regWrite) begin
            rf[writeReg] <= writeData;
            wlog.push_back({writeReg, writeData});
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle();
        aluValid = 1'b0;
        memValid = 1'b0;
    endtask

    initial begin
        int ai, mi, n0;
        logic a_x, m_x;
        logic [ADDR_W+DATA_W-1:0] exp_e;

        idle();
        aluReg = '0; aluData = '0; memReg = '0; memData = '0;
        @(negedge clock);
        chk("rst_regwrite", regWrite, 0);
        chk("rst_writereg", writeReg, 0);
        chk("rst_writedata", writeData, 0);
        chk("rst_busy", busyMask, 0);
        chk("rst_alu_ready", aluReady, 0);
        chk("rst_mem_ready", memReady, 0);
        resetN = 1'b1;
        tick();
        chk("rel_alu_ready", aluReady, 1);
        chk("rel_mem_ready", memReady, 1);
        chk("rel_regwrite", regWrite, 0);

        // Single ALU result
        aluValid = 1'b1; aluReg = 5; aluData = 32'hDEADBEEF;
        chk("t2_ready", aluReady, 1);
        tick();
        idle();
        chk("t2_busy_e1", busyMask, 32'h20);
`ifdef WB_BYPASS_EN
        chk("t2_we_e1", regWrite, 1);
        chk("t2_reg_e1", writeReg, 5);
        chk("t2_data_e1", writeData, 32'hDEADBEEF);
        tick();
        chk("t2_we_e2", regWrite, 0);
        chk("t2_busy_e2", busyMask, 0);
`else
        chk("t2_we_e1", regWrite, 0);
        tick();
        chk("t2_we_e2", regWrite, 1);
        chk("t2_reg_e2", writeReg, 5);
        chk("t2_data_e2", writeData, 32'hDEADBEEF);
        chk("t2_busy_e2", busyMask, 32'h20);
        tick();
        chk("t2_we_e3", regWrite, 0);
        chk("t2_hold_reg", writeReg, 5);
        chk("t2_busy_e3", busyMask, 0);
`endif
        tick();

        // Same-register collision: mem first on a tie
        memValid = 1'b1; memReg = 7; memData = 32'h11;
        aluValid = 1'b1; aluReg = 7; aluData = 32'h22;
        tick();
        idle();
        chk("t3_busy", busyMask, 32'h80);
        chk("t3_we_e1", regWrite, 0);
        tick();
        chk("t3_we_e2", regWrite, 1);
        chk("t3_reg_e2", writeReg, 7);
        chk("t3_data_e2", writeData, 32'h11);
        tick();
        chk("t3_we_e3", regWrite, 1);
        chk("t3_data_e3", writeData, 32'h22);
        tick();
        chk("t3_we_e4", regWrite, 0);
        chk("t3_rf7", rf[7], 32'h22);

        // Writes to r0 are absorbed
        aluValid = 1'b1; aluReg = 0; aluData = 32'hFFFF;
        chk("t4_ready", aluReady, 1);
        tick();
        idle();
        chk("t4_we_e1", regWrite, 0);
        chk("t4_busy_e1", busyMask, 0);
        tick();
        chk("t4_we_e2", regWrite, 0);
        chk("t4_busy_e2", busyMask, 0);
        tick();

        // Saturation: alu regs 1..8, mem regs 9..16
        wlog.delete();
        ai = 0; mi = 0;
        for (int cyc = 0; cyc < 40 && (ai < 8 || mi < 8); cyc++) begin
            aluValid = (ai < 8);
            aluReg   = ADDR_W'(ai + 1);
            aluData  = 32'hA000_0000 + 32'(ai + 1);
            memValid = (mi < 8);
            memReg   = ADDR_W'(mi + 9);
            memData  = 32'hB000_0000 + 32'(mi + 9);
            if (aluValid && memValid && cyc > 0)
                chk("t5_ready_alt", aluReady ^ memReady, 1);
            a_x = aluValid && aluReady;
            m_x = memValid && memReady;
            tick();
            if (a_x) ai++;
            if (m_x) mi++;
        end
        idle();
        chk("t5_alu_sent", ai, 8);
        chk("t5_mem_sent", mi, 8);
        for (int w = 0; w < 10 && wlog.size() < 16; w++) tick();
        chk("t5_count", wlog.size(), 16);
        for (int k = 0; k < 16; k++) begin
            if (k % 2 == 0)
                exp_e = {ADDR_W'(9 + k/2), 32'hB000_0000 + 32'(9 + k/2)};
            else
                exp_e = {ADDR_W'(1 + k/2), 32'hA000_0000 + 32'(1 + k/2)};
            if (k < wlog.size())
                chk("t5_order", wlog[k], exp_e);
        end
        tick();

        // Reset mid-stream while a write is on the outputs
        aluValid = 1'b1; aluReg = 3; aluData = 32'h33;
        memValid = 1'b1; memReg = 4; memData = 32'h44;
        tick();
        idle();
        tick();
        chk("t1_pre_we", regWrite, 1);
        chk("t1_pre_reg", writeReg, 4);
        #2 resetN = 1'b0;
        #1;
        n0 = wlog.size();
        chk("t1_mid_we", regWrite, 0);
        chk("t1_mid_reg", writeReg, 0);
        chk("t1_mid_data", writeData, 0);
        chk("t1_mid_busy", busyMask, 0);
        chk("t1_mid_alu_ready", aluReady, 0);
        chk("t1_mid_mem_ready", memReady, 0);
        @(negedge clock);
        resetN = 1'b1;
        tick();
        chk("t1_rel_alu_ready", aluReady, 1);
        chk("t1_rel_mem_ready", memReady, 1);
        chk("t1_rel_we", regWrite, 0);
        tick();
        tick();
        chk("t1_no_spurious", wlog.size(), n0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
